// File: rtl/alu_exec_unit.sv
// Multi-cycle integer execute unit: addu/subu/and in one step, sll iterated one bit per cycle.
// Operands enter through a valid/ready handshake; the result is held until out_ready.
module alu_exec_unit #(
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned SHAMT_W = 5
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [5:0]         funct,
   input  logic [DATA_W-1:0]  src1,
   input  logic [DATA_W-1:0]  src2,
   input  logic [SHAMT_W-1:0] shamt,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [DATA_W-1:0]  result,
   output logic               zero,
   output logic               illegal,
   output logic               busy
);

   localparam logic [5:0] FnAddu = 6'b001001;
   localparam logic [5:0] FnSubu = 6'b001010;
   localparam logic [5:0] FnAnd  = 6'b010001;
   localparam logic [5:0] FnSll  = 6'b100001;

   typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

   state_e             state_q, state_d;
   logic [DATA_W-1:0]  acc_q, acc_d;
   logic [SHAMT_W-1:0] cnt_q, cnt_d;
   logic [DATA_W-1:0]  result_q, result_d;
   logic               zero_q, zero_d;
   logic               illegal_q, illegal_d;

   // load/load_val funnel every path into DONE so zero is always derived from the stored result
   logic               load;
   logic [DATA_W-1:0]  load_val;

   always_comb begin
      state_d   = state_q;
      acc_d     = acc_q;
      cnt_d     = cnt_q;
      result_d  = result_q;
      zero_d    = zero_q;
      illegal_d = illegal_q;
      load      = 1'b0;
      load_val  = '0;

      unique case (state_q)
         StIdle: begin
            if (in_valid) begin
               illegal_d = 1'b0;
               case (funct)
                  FnAddu: begin
                     load     = 1'b1;
                     load_val = src1 + src2;
                  end
                  FnSubu: begin
                     load     = 1'b1;
                     load_val = src1 - src2;
                  end
                  FnAnd: begin
                     load     = 1'b1;
                     load_val = src1 & src2;
                  end
                  FnSll: begin
                     if (shamt == '0) begin
                        load     = 1'b1;
                        load_val = src2;
                     end else begin
                        acc_d   = src2;
                        cnt_d   = shamt;
                        state_d = StShift;
                     end
                  end
                  default: begin
                     load      = 1'b1;
                     load_val  = '0;
                     illegal_d = 1'b1;
                  end
               endcase
            end
         end
         StShift: begin
            acc_d = acc_q << 1;
            cnt_d = cnt_q - SHAMT_W'(1);
            if (cnt_q == SHAMT_W'(1)) begin
               load     = 1'b1;
               load_val = acc_q << 1;
            end
         end
         StDone: begin
            if (out_ready) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase

      if (load) begin
         result_d = load_val;
         zero_d   = (load_val == '0);
         state_d  = StDone;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         acc_q     <= '0;
         cnt_q     <= '0;
         result_q  <= '0;
         zero_q    <= 1'b0;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         acc_q     <= acc_d;
         cnt_q     <= cnt_d;
         result_q  <= result_d;
         zero_q    <= zero_d;
         illegal_q <= illegal_d;
      end
   end

   assign in_ready  = (state_q == StIdle);
   assign busy      = (state_q != StIdle);
   assign out_valid = (state_q == StDone);
   assign result    = result_q;
   assign zero      = zero_q;
   assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit: a driver pushes expected responses from an arithmetic
// reference model, a monitor compares them while out_valid is presented.
module tb_alu_exec_unit;

   localparam logic [5:0] ADDU = 6'b001001;
   localparam logic [5:0] SUBU = 6'b001010;
   localparam logic [5:0] ANDF = 6'b010001;
   localparam logic [5:0] SLL  = 6'b100001;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [5:0]  funct = '0;
   logic [31:0] src1 = '0;
   logic [31:0] src2 = '0;
   logic [4:0]  shamt = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] result;
   logic        zero;
   logic        illegal;
   logic        busy;

   typedef struct {
      logic [31:0] res;
      logic        z;
      logic        ill;
      int unsigned due;
   } exp_t;

   exp_t        sb[$];
   int unsigned cyc = 0;
   int          checks = 0;
   int          errors = 0;
   bit          seen_first = 1'b0;
   logic [5:0]  codes [4];

   alu_exec_unit #(.DATA_W(32), .SHAMT_W(5)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .funct(funct),
      .src1(src1), .src2(src2), .shamt(shamt), .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .zero(zero), .illegal(illegal), .busy(busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Reference: the architectural meaning of each code, plus when its output should first appear
   function automatic exp_t model(logic [5:0] f, logic [31:0] a, logic [31:0] b,
                                  logic [4:0] sh, int unsigned acc_cyc);
      exp_t e;
      e.ill = 1'b0;
      e.due = acc_cyc;
      case (f)
         ADDU: e.res = a + b;
         SUBU: e.res = a - b;
         ANDF: e.res = a & b;
         SLL: begin
            e.res = b << sh;
            e.due = acc_cyc + sh;
         end
         default: begin
            e.res = '0;
            e.ill = 1'b1;
         end
      endcase
      e.z = (e.res == 32'd0);
      return e;
   endfunction

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%h expected 0x%h at cycle %0d", name, act, exp, cyc);
      end
   endtask

   // Monitor
   initial begin
      forever begin
         @(negedge clk);
         #1;
         if (rst_n && out_valid) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_output: got result 0x%h expected no output", result);
            end else begin
               if (!seen_first) begin
                  check("latency", cyc, sb[0].due);
                  seen_first = 1'b1;
               end
               check("result", result, sb[0].res);
               check("zero", 32'(zero), 32'(sb[0].z));
               check("illegal", 32'(illegal), 32'(sb[0].ill));
               check("in_ready_in_done", 32'(in_ready), 32'd0);
               if (out_ready) begin
                  void'(sb.pop_front());
                  seen_first = 1'b0;
               end
            end
         end
      end
   end

   task automatic drive(bit v, logic [5:0] f, logic [31:0] a, logic [31:0] b, logic [4:0] sh,
                        bit ordy, output bit accepted);
      @(negedge clk);
      in_valid  = v;
      funct     = f;
      src1      = a;
      src2      = b;
      shamt     = sh;
      out_ready = ordy;
      accepted  = v && in_ready && rst_n;
      if (accepted) sb.push_back(model(f, a, b, sh, cyc + 1));
   endtask

   task automatic idle(bit ordy);
      bit dummy;
      drive(1'b0, '0, '0, '0, '0, ordy, dummy);
   endtask

   task automatic issue(logic [5:0] f, logic [31:0] a, logic [31:0] b, logic [4:0] sh, bit ordy);
      bit ok = 1'b0;
      for (int i = 0; i < 100 && !ok; i++) drive(1'b1, f, a, b, sh, ordy, ok);
      if (!ok) begin
         checks++;
         errors++;
         $display("FAIL issue_timeout: got in_ready 0 expected 1 within 100 cycles");
      end
   endtask

   task automatic drain();
      for (int i = 0; i < 100; i++) begin
         idle(1'b1);
         #2;
         if (sb.size() == 0 && !out_valid) break;
      end
      check("drain", 32'(sb.size()), 32'd0);
   endtask

   initial begin
      bit          acc;
      bit          v;
      bit          ordy;
      int unsigned pick;
      logic [5:0]  f;
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  sh;

      codes[0] = ADDU;
      codes[1] = SUBU;
      codes[2] = ANDF;
      codes[3] = SLL;

      #2;
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_result", result, 32'd0);
      check("rst_zero", 32'(zero), 32'd0);
      check("rst_illegal", 32'(illegal), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Directed cases
      issue(ADDU, 32'h5, 32'h3, 5'd0, 1'b1);
      drain();
      issue(SUBU, 32'h0, 32'h1, 5'd0, 1'b1);
      drain();
      issue(SUBU, 32'h1234_5678, 32'h1234_5678, 5'd0, 1'b1);
      drain();
      issue(SLL, 32'h0, 32'h8000_0001, 5'd4, 1'b0);
      for (int i = 0; i < 5; i++) begin
         idle(1'b0);
         #2;
         check("sll_in_ready", 32'(in_ready), 32'd0);
         check("sll_out_valid", 32'(out_valid), (i == 4) ? 32'd1 : 32'd0);
      end
      drain();
      issue(SLL, 32'hFFFF_FFFF, 32'hA5A5_A5A5, 5'd0, 1'b1);
      drain();
      issue(6'b000000, 32'h7, 32'h9, 5'd3, 1'b1);
      drain();

      // Backpressure: held result is compared by the monitor every cycle
      issue(ANDF, $urandom, $urandom, 5'd0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         idle(1'b0);
         #2;
         check("hold_valid", 32'(out_valid), 32'd1);
      end
      drain();

      // Randomized traffic, including in_valid while busy and random out_ready
      for (int n = 0; n < 600; n++) begin
         v    = ($urandom_range(0, 1) == 1);
         pick = $urandom_range(0, 4);
         f    = (pick < 4) ? codes[pick] : 6'($urandom);
         a    = $urandom;
         b    = ($urandom_range(0, 7) == 0) ? a : $urandom;
         sh   = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 4));
         ordy = ($urandom_range(0, 3) != 0);
         drive(v, f, a, b, sh, ordy, acc);
      end
      drain();

      // Reset in the middle of a long shift
      issue(SLL, 32'h0, $urandom | 32'h1, 5'd31, 1'b1);
      repeat (5) idle(1'b1);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("midrst_out_valid", 32'(out_valid), 32'd0);
      check("midrst_in_ready", 32'(in_ready), 32'd1);
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_result", result, 32'd0);
      sb.delete();
      seen_first = 1'b0;
      repeat (2) idle(1'b1);
      rst_n = 1'b1;
      repeat (40) idle(1'b1);
      check("post_rst_busy", 32'(busy), 32'd0);
      issue(ADDU, 32'hFFFF_FFFF, 32'h1, 5'd0, 1'b1);
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
